// File: rtl/fifo_n_base.sv
// fifo_n_base: parametrised N-entry, W-bit FIFO with the enq/deq/first
// method-handshake port set, plus occupancy count, almost-full flag and a
// synchronous flush (clear).
//
// Storage is a circular register array. It is addressed by a read pointer and
// a write pointer. Full and empty are decided from the explicit occupancy
// count. They are never decided from pointer equality.
//
// Ports:
//   CLK            clock, all state updates on the rising edge
//   RST            synchronous active-high reset (overrides everything)
//   in_enq__ENA    enqueue request (ignored while not ready)
//   in_enq_v       enqueue data
//   in_enq__RDY    FIFO not full
//   in_clear__ENA  flush all entries (priority over enq/deq)
//   in_clear__RDY  constant 1
//   out_deq__ENA   dequeue request (ignored while not ready)
//   out_deq__RDY   FIFO not empty
//   out_first      head element (don't-care when empty)
//   out_first__RDY FIFO not empty
//   out_count      current occupancy, 0..DEPTH
//   out_afull      count >= AFULL
module fifo_n_base #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AFULL = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             in_clear__ENA,
  output logic             in_clear__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY,
  output logic [CW-1:0]    out_count,
  output logic             out_afull
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr_reg, rptr_next;
  logic [PW-1:0]    wptr_reg, wptr_next;
  logic [CW-1:0]    count_reg, count_next;

  logic full;
  logic empty;
  logic enq;
  logic deq;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // Requests made while not ready are silently dropped here.
  assign enq = in_enq__ENA & ~full;
  assign deq = out_deq__ENA & ~empty;

  always_comb begin
    rptr_next  = rptr_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    if (in_clear__ENA) begin
      rptr_next  = '0;
      wptr_next  = '0;
      count_next = '0;
    end else begin
      if (enq) wptr_next = wptr_reg + 1'b1;
      if (deq) rptr_next = rptr_reg + 1'b1;
      // A simultaneous enq and deq leaves the count unchanged.
      case ({enq, deq})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
    end
  end

  // The storage array has no reset. Writes are suppressed under reset and
  // clear, so a discarded enq leaves no trace.
  always_ff @(posedge CLK) begin
    if (enq && !RST && !in_clear__ENA) begin
      mem[wptr_reg] <= in_enq_v;
    end
  end

  // Every output comes from registered state only. There is no path from
  // any __ENA input.
  assign in_enq__RDY    = ~full;
  assign in_clear__RDY  = 1'b1;
  assign out_deq__RDY   = ~empty;
  assign out_first__RDY = ~empty;
  assign out_first      = mem[rptr_reg];
  assign out_count      = count_reg;
  assign out_afull      = (count_reg >= CW'(AFULL));

endmodule

// File: tb/tb_fifo_n_base.sv
// Testbench for fifo_n_base (WIDTH=16, DEPTH=4, AFULL=3).
// A queue-based reference model is checked against the DUT on every falling
// edge. Directed steps also carry hand-computed literal expectations.
module tb_fifo_n_base;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enq_ena = 1'b0;
  logic [WIDTH-1:0] enq_v = '0;
  logic             enq_rdy;
  logic             clr_ena = 1'b0;
  logic             clr_rdy;
  logic             deq_ena = 1'b0;
  logic             deq_rdy;
  logic [WIDTH-1:0] first;
  logic             first_rdy;
  logic [CW-1:0]    count;
  logic             afull;

  int checks = 0;
  int errors = 0;

  fifo_n_base #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .CLK            (clk),
    .RST            (rst),
    .in_enq__ENA    (enq_ena),
    .in_enq_v       (enq_v),
    .in_enq__RDY    (enq_rdy),
    .in_clear__ENA  (clr_ena),
    .in_clear__RDY  (clr_rdy),
    .out_deq__ENA   (deq_ena),
    .out_deq__RDY   (deq_rdy),
    .out_first      (first),
    .out_first__RDY (first_rdy),
    .out_count      (count),
    .out_afull      (afull)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted elements.
  logic [WIDTH-1:0] q[$];
  bit model_on = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      model_on = 1;
    end else if (model_on) begin
      if (clr_ena) begin
        q.delete();
      end else begin
        int sz;
        sz = q.size();
        if (deq_ena && sz > 0) void'(q.pop_front());
        if (enq_ena && sz < DEPTH) q.push_back(enq_v);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      int sz;
      sz = q.size();
      check("m_count", 32'(count), 32'(sz));
      check("m_enq_rdy", 32'(enq_rdy), 32'(sz < DEPTH));
      check("m_deq_rdy", 32'(deq_rdy), 32'(sz > 0));
      check("m_first_rdy", 32'(first_rdy), 32'(sz > 0));
      check("m_afull", 32'(afull), 32'(sz >= AFULL));
      check("m_clr_rdy", 32'(clr_rdy), 32'd1);
      if (sz > 0) check("m_first", 32'(first), 32'(q[0]));
    end
  end

  // Apply one cycle of inputs. Return 1ns after the capturing edge.
  task automatic drive(input bit r, input bit e, input logic [WIDTH-1:0] v,
                       input bit d, input bit c);
    rst = r; enq_ena = e; enq_v = v; deq_ena = d; clr_ena = c;
    @(posedge clk);
    #1;
    rst = 0; enq_ena = 0; deq_ena = 0; clr_ena = 0;
    $display("txn rst=%0b enq=%0b v=0x%04h deq=%0b clr=%0b -> count=%0d first=0x%04h",
             r, e, v, d, c, count, first);
  endtask

  logic [WIDTH-1:0] expv;

  initial begin
    // Reset and fill.
    @(negedge clk);
    drive(1, 0, '0, 0, 0);
    drive(1, 0, '0, 0, 0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_enq_rdy", 32'(enq_rdy), 32'd1);
    check("rst_deq_rdy", 32'(deq_rdy), 32'd0);
    check("rst_first_rdy", 32'(first_rdy), 32'd0);
    check("rst_afull", 32'(afull), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, WIDTH'(i), 0, 0);
      check("fill_count", 32'(count), 32'(i));
      check("fill_afull", 32'(afull), (i >= 3) ? 32'd1 : 32'd0);
    end
    check("full_enq_rdy", 32'(enq_rdy), 32'd0);
    drive(0, 1, 16'hDEAD, 0, 0);
    check("enq_when_full_count", 32'(count), 32'd4);
    check("enq_when_full_first", 32'(first), 32'h0001);

    // Drain order.
    for (int i = 1; i <= 4; i++) begin
      check("drain_first", 32'(first), 32'(i));
      drive(0, 0, '0, 1, 0);
    end
    check("drain_deq_rdy", 32'(deq_rdy), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    drive(0, 0, '0, 1, 0);
    check("deq_when_empty_count", 32'(count), 32'd0);

    // Simultaneous enq/deq across pointer wrap.
    drive(0, 1, 16'h0010, 0, 0);
    drive(0, 1, 16'h0011, 0, 0);
    for (int i = 0; i < 10; i++) begin
      expv = (i < 2) ? WIDTH'(16'h0010 + i) : WIDTH'(16'h0100 + i - 2);
      check("wrap_first", 32'(first), 32'(expv));
      drive(0, 1, WIDTH'(16'h0100 + i), 1, 0);
      check("wrap_count", 32'(count), 32'd2);
    end
    // Queue now holds 0x0108, 0x0109.

    // Full with a deq request.
    drive(0, 1, 16'h0020, 0, 0);
    drive(0, 1, 16'h0021, 0, 0);
    check("full2_count", 32'(count), 32'd4);
    drive(0, 1, 16'h00AA, 1, 0);
    check("full_deq_count", 32'(count), 32'd3);
    check("full_deq_enq_rdy", 32'(enq_rdy), 32'd1);
    drive(0, 1, 16'h00AA, 0, 0);
    check("refill_count", 32'(count), 32'd4);
    check("refill_first", 32'(first), 32'h0109);
    drive(0, 0, '0, 1, 0);
    check("refill_first2", 32'(first), 32'h0020);
    drive(0, 0, '0, 1, 0);
    check("refill_first3", 32'(first), 32'h0021);
    drive(0, 0, '0, 1, 0);
    check("refill_last", 32'(first), 32'h00AA);
    drive(0, 0, '0, 1, 0);
    check("refill_empty", 32'(count), 32'd0);

    // Clear priority.
    drive(0, 1, 16'h0030, 0, 0);
    drive(0, 1, 16'h0031, 0, 0);
    drive(0, 1, 16'h0032, 0, 0);
    check("pre_clr_count", 32'(count), 32'd3);
    drive(0, 1, 16'h0077, 1, 1);
    check("clr_count", 32'(count), 32'd0);
    check("clr_deq_rdy", 32'(deq_rdy), 32'd0);
    check("clr_afull", 32'(afull), 32'd0);
    drive(0, 1, 16'h0055, 0, 0);
    check("post_clr_first", 32'(first), 32'h0055);
    check("post_clr_first_rdy", 32'(first_rdy), 32'd1);
    check("post_clr_count", 32'(count), 32'd1);

    // Reset mid-operation with enq asserted.
    drive(0, 1, 16'h0066, 0, 0);
    check("pre_rst_count", 32'(count), 32'd2);
    drive(1, 1, 16'h0099, 0, 0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_enq_rdy", 32'(enq_rdy), 32'd1);
    check("mid_rst_first_rdy", 32'(first_rdy), 32'd0);
    drive(0, 0, '0, 0, 0);
    check("post_rst_count", 32'(count), 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
